// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/memory pipeline stages, the unified memory and the arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic [31:0]       d_rdata;
  logic              flush;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              sel_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter: fetch vs. memory-stage access, data-first priority
// with fetch anti-starvation, fixed-latency issue/wait/response sequencing and flush cancel.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int   LAT_W     = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int   STV_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [31:0]       wdata_r;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic [STV_W-1:0]  starve_cnt_r;
  logic              cancel_r;
  logic [31:0]       if_rdata_r;
  logic [31:0]       d_rdata_r;

  logic arb_s;
  logic elig_f_s;
  logic elig_d_s;
  logic grant_f_s;
  logic grant_d_s;
  logic lat_done_s;
  logic mem_en_s;
  logic mem_we_s;
  logic if_ready_s;
  logic d_ready_s;

  assign lat_done_s = (lat_cnt_r == LAT_W'(MEM_LAT));

  // Grant decision; in RESP the finishing owner's still-high request is the old one and is masked
  always_comb begin
    arb_s     = (state_r == ST_IDLE) || (state_r == ST_RESP);
    elig_f_s  = bus.if_req && !((state_r == ST_RESP) && (owner_r == OWN_FETCH));
    elig_d_s  = bus.d_req  && !((state_r == ST_RESP) && (owner_r == OWN_DATA));
    grant_f_s = 1'b0;
    grant_d_s = 1'b0;
    if (arb_s) begin
      if (elig_f_s && elig_d_s) begin
        if (starve_cnt_r == STV_W'(STARVE_MAX)) begin
          grant_f_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
      end else begin
        grant_f_s = elig_f_s;
        grant_d_s = elig_d_s;
      end
    end else begin
      grant_f_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = (grant_f_s || grant_d_s) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT:  state_next_s = lat_done_s ? ST_RESP : ST_WAIT;
      ST_RESP:  state_next_s = (grant_f_s || grant_d_s) ? ST_ISSUE : ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    mem_en_s   = 1'b0;
    mem_we_s   = 1'b0;
    if_ready_s = 1'b0;
    d_ready_s  = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        mem_en_s = 1'b1;
        mem_we_s = we_r;
      end
      ST_RESP: begin
        if_ready_s = (owner_r == OWN_FETCH) && !cancel_r;
        d_ready_s  = (owner_r == OWN_DATA);
      end
      default: begin
        mem_en_s   = 1'b0;
        mem_we_s   = 1'b0;
        if_ready_s = 1'b0;
        d_ready_s  = 1'b0;
      end
    endcase
  end

  // Request latch, latency count, starvation count, flush cancel and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r      <= OWN_FETCH;
      addr_r       <= {ADDR_W{1'b0}};
      we_r         <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      lat_cnt_r    <= {LAT_W{1'b0}};
      starve_cnt_r <= {STV_W{1'b0}};
      cancel_r     <= 1'b0;
      if_rdata_r   <= 32'h0000_0000;
      d_rdata_r    <= 32'h0000_0000;
    end else begin
      // addr_r doubles as mem_addr: it only moves at the edge into ISSUE, so it holds elsewhere
      if (grant_d_s) begin
        owner_r <= OWN_DATA;
        addr_r  <= bus.d_addr;
        we_r    <= bus.d_we;
        wdata_r <= bus.d_wdata;
      end else if (grant_f_s) begin
        owner_r <= OWN_FETCH;
        addr_r  <= bus.if_addr;
        we_r    <= 1'b0;
      end

      case (state_r)
        ST_ISSUE: lat_cnt_r <= LAT_W'(1);
        ST_WAIT:  lat_cnt_r <= lat_cnt_r + LAT_W'(1);
        default:  lat_cnt_r <= {LAT_W{1'b0}};
      endcase

      if (arb_s) begin
        if (!bus.if_req || grant_f_s) begin
          starve_cnt_r <= {STV_W{1'b0}};
        end else if (grant_d_s && (starve_cnt_r != STV_W'(STARVE_MAX))) begin
          starve_cnt_r <= starve_cnt_r + STV_W'(1);
        end
      end

      // A flush together with a new fetch grant cancels that new fetch, overriding the RESP clear
      if (grant_f_s && bus.flush) begin
        cancel_r <= 1'b1;
      end else if (((state_r == ST_ISSUE) || (state_r == ST_WAIT)) && (owner_r == OWN_FETCH) && bus.flush) begin
        cancel_r <= 1'b1;
      end else if (state_r == ST_RESP) begin
        cancel_r <= 1'b0;
      end

      if ((state_r == ST_WAIT) && lat_done_s) begin
        if (owner_r == OWN_FETCH) begin
          if_rdata_r <= bus.mem_rdata;
        end else if (!we_r) begin
          d_rdata_r <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.if_ready  = if_ready_s;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_ready   = d_ready_s;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.sel_stall = bus.d_req && !d_ready_s;
endmodule
